// File: rtl/queue_sched_pkg.sv
// Shared types and helpers for the queue pop scheduler.
// Scheduler state, scan result type and the round-robin nonempty scan.
package queue_sched_pkg;

  localparam int unsigned DefNumReqs = 4;
  localparam int unsigned DefDepth   = 8;
  localparam int unsigned DefQwid    = 3;

  // Upper bound on requesters supported by the scan helper.
  localparam int unsigned MaxReqs = 32;
  localparam int unsigned IdxMaxW = 5;

  typedef enum logic [0:0] {
    IDLE,
    SERVE
  } sched_state_e;

  typedef struct packed {
    logic               found;
    logic [IdxMaxW-1:0] idx;
  } scan_t;

  // First set bit of nonempty_vec scanning start, start+1, ... modulo n.
  // start may equal n, which aliases to index 0.
  function automatic scan_t next_nonempty(input int unsigned        start,
                                          input logic [MaxReqs-1:0] nonempty_vec,
                                          input int unsigned        n);
    scan_t       res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < MaxReqs; k++) begin
      j = start + k;
      if (j >= n) j = j - n;
      if (k < n && !res.found && nonempty_vec[j[IdxMaxW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[IdxMaxW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/queue_occ_counter.sv
// Occupancy counter for one packet FIFO, driven by its push/pop strobes.
// Exposes the registered count, the next-state count and a full flag.
module queue_occ_counter #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNTWID = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  output logic [CNTWID-1:0] cnt,
  output logic [CNTWID-1:0] next_cnt,
  output logic              full
);

  localparam logic [CNTWID-1:0] MaxCnt = CNTWID'(DEPTH);

  logic [CNTWID-1:0] cnt_q;

  // A push while full is dropped; push and pop together cancel.
  always_comb begin
    next_cnt = cnt_q;
    if (push && !pop && cnt_q != MaxCnt) begin
      next_cnt = cnt_q + CNTWID'(1);
    end else if (pop && !push && cnt_q != '0) begin
      next_cnt = cnt_q - CNTWID'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= next_cnt;
    end
  end

  assign cnt  = cnt_q;
  assign full = (cnt_q == MaxCnt);

endmodule

// File: rtl/queue_pop_scheduler.sv
// Round-robin pop scheduler for NUM_REQS packet FIFOs sharing one output port.
// Define WRR_WEIGHT_EN for per-queue quantum credits; otherwise one pop per visit.
module queue_pop_scheduler
  import queue_sched_pkg::*;
#(
  parameter int unsigned NUM_REQS = DefNumReqs,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned CNTWID   = $clog2(DEPTH + 1),
  parameter int unsigned QWID     = DefQwid
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQS-1:0]          push,
  input  logic                         blk,
  input  logic [NUM_REQS*QWID-1:0]     quantums,
  output logic [NUM_REQS-1:0]          pop,
  output logic [$clog2(NUM_REQS)-1:0]  gnt_idx,
  output logic                         gnt_vld,
  output logic [NUM_REQS-1:0]          full,
  output logic [NUM_REQS*CNTWID-1:0]   cnt
);

  localparam int unsigned IdxW = $clog2(NUM_REQS);

  sched_state_e    state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [QWID-1:0] credit_q, credit_d;

  logic [NUM_REQS-1:0][CNTWID-1:0] cur_cnt;
  logic [NUM_REQS-1:0][CNTWID-1:0] nxt_cnt;
  logic [NUM_REQS-1:0][QWID-1:0]   load_q;
  logic [NUM_REQS-1:0]             nonempty_cur;
  logic [NUM_REQS-1:0]             nonempty_nxt;

  scan_t           scan_cur, scan_nxt;
  logic [IdxW-1:0] idx_cur, idx_nxt;
  logic            unused_scan_bits;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_queue
    queue_occ_counter #(
      .DEPTH  (DEPTH),
      .CNTWID (CNTWID)
    ) u_occ (
      .clk      (clk),
      .rst      (rst),
      .push     (push[i]),
      .pop      (pop[i]),
      .cnt      (cur_cnt[i]),
      .next_cnt (nxt_cnt[i]),
      .full     (full[i])
    );

    assign nonempty_cur[i] = (cur_cnt[i] != '0);
    assign nonempty_nxt[i] = (nxt_cnt[i] != '0);

`ifdef WRR_WEIGHT_EN
    // A zero quantum still grants one pop so the queue cannot starve.
    assign load_q[i] = (quantums[i*QWID +: QWID] == '0) ? QWID'(1) : quantums[i*QWID +: QWID];
`else
    assign load_q[i] = QWID'(1);
`endif
  end

`ifndef WRR_WEIGHT_EN
  logic unused_quantums;
  assign unused_quantums = ^quantums;
`endif

  assign cnt = cur_cnt;

  // Idle entry scans from ptr itself on registered counts; visit end scans from
  // ptr+1 on next-state counts so a change of queue costs no bubble cycle.
  assign scan_cur = next_nonempty(32'(ptr_q), MaxReqs'(nonempty_cur), NUM_REQS);
  assign scan_nxt = next_nonempty(32'(ptr_q) + 32'd1, MaxReqs'(nonempty_nxt), NUM_REQS);
  assign idx_cur  = scan_cur.idx[IdxW-1:0];
  assign idx_nxt  = scan_nxt.idx[IdxW-1:0];
  assign unused_scan_bits = ^{scan_cur.idx, scan_nxt.idx};

  // Reset gates the strobe so no FIFO pops in the reset cycle.
  always_comb begin
    pop = '0;
    if (!rst && !blk && state_q == SERVE && cur_cnt[ptr_q] != '0 && credit_q != '0) begin
      pop[ptr_q] = 1'b1;
    end
  end

  assign gnt_vld = |pop;
  assign gnt_idx = ptr_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    unique case (state_q)
      IDLE: begin
        if (scan_cur.found) begin
          state_d  = SERVE;
          ptr_d    = idx_cur;
          credit_d = load_q[idx_cur];
        end
      end
      SERVE: begin
        if (gnt_vld) begin
          credit_d = credit_q - QWID'(1);
          if (credit_q == QWID'(1) || nxt_cnt[ptr_q] == '0) begin
            if (scan_nxt.found) begin
              ptr_d    = idx_nxt;
              credit_d = load_q[idx_nxt];
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

endmodule
